load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage data-memory client of the RV32I pipeline, sitting between the EX/MEM register and the data-memory bus.
- Converts load/store control from EX/MEM into a valid/ready request and a registered response.
- Performs store lane steering and byte strobes, and load extraction with sign/zero-extension.
- Stalls the pipeline until the access completes, then presents aligned load data for the MEM/WB register to capture.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the data bus; the data width is fixed at 32.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  EX/MEM load request
- mem_write  in  1  EX/MEM store request; mem_read and mem_write are never both 1
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_WIDTH  byte address from ALU result
- store_data  in  32  rs2 value
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- load_data  out  32  extended load result, valid in DONE
- mem_exc  out  1  misaligned access or illegal funct3 for this op
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  ADDR_WIDTH  word-aligned address, addr[1:0] forced to 00
- req_wdata  out  32  lane-replicated store data
- req_wstrb  out  4  byte enables; 0000 for reads
- resp_valid  in  1  read data valid, one-cycle pulse
- resp_rdata  in  32  read word

Behaviour:
- Reset, asynchronous on rst_n low:
  - state goes to IDLE.
  - req_valid, req_we, req_addr, req_wdata, req_wstrb and load_data are all 0.
  - stall and mem_exc are forced to 0 while rst_n is low.
- Request inputs are held stable by the pipeline while stall is 1.
- Access is legal when:
  - funct3 is 000 or 100, any address;
  - funct3 is 001 or 101, addr[0]=0;
  - funct3 is 010, addr[1:0]=00.
  - Stores allow only 000, 001 and 010.
- mem_exc is combinational: 1 in IDLE when (mem_read|mem_write) and the access is illegal.
  - No bus request is issued and stall=0; the op passes through as a one-cycle exception.
- start = IDLE & (mem_read|mem_write) & legal.
- FSM states are IDLE, REQ, RESP and DONE.
  - IDLE: when start, register req_* and the byte offset, then go to REQ.
  - REQ: req_valid=1, with req_* held constant until accepted.
    - req_valid & req_ready & req_we goes to DONE.
    - req_valid & req_ready & !req_we goes to RESP.
  - RESP: wait for resp_valid, then capture the extracted data into load_data and go to DONE.
  - DONE: lasts one cycle, then goes to IDLE. The pipeline advances at the end of DONE and MEM/WB samples load_data.
- stall = start | (state==REQ) | (state==RESP). stall is 0 in DONE.
- resp_valid is sampled only in RESP. In IDLE, REQ and DONE it is ignored, including stale responses after reset.
- req_ready is sampled only in REQ.
- Store data:
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=sd, wstrb=1111.
- Load extraction: shift resp_rdata right by 8*offset, then:
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes the word unchanged.
- load_data holds its value until the next load reaches DONE. It is undefined for stores but is not modified by them.
- Latency with zero-wait memory:
  - Store: 3 cycles (IDLE, REQ, DONE), stall high for 2 of them.
  - Load with resp_valid one cycle after acceptance: 4 cycles, stall high for 3 of them.
- Reset mid-operation: the transaction is abandoned, req_valid drops immediately, and no retry is made.

Decomposition:
- Package riscv_lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state encoding (2-bit, IDLE=00);
  - the legal-access function.
- One combinational sub-module, lsu_align, holds store lane/strobe generation and load extract/extend.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SW, addr=0x0000_1004, sd=0xDEADBEEF, req_ready=1 → 1-cycle REQ with req_addr=0x1004, wstrb=1111, wdata=0xDEADBEEF; DONE on the third cycle; stall high for 2 cycles.
- SB, addr=0x0000_1003, sd=0x0000_00A5 → wstrb=1000, wdata=0xA5A5A5A5. With req_ready low for 3 cycles: req_* held constant and stall high throughout.
- LB at addr offset 2, resp_rdata=0x1280_3456 → load_data=0xFFFF_FF80 in DONE. Same setup with LBU → load_data=0x0000_0080.
- LH, addr=0x0000_2001 → mem_exc=1 for one cycle, stall=0, req_valid never asserted, load_data unchanged.
- LW issued, rst_n pulsed low while in RESP → req_valid=0 and state IDLE immediately. A resp_valid arriving after reset is ignored, and load_data stays 0.
- Back-to-back LHU(offset 2, rdata=0xBEEF_0000) then SW → first DONE shows load_data=0x0000_BEEF; the next cycle is IDLE with stall=1 for the store.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM
// state encoding and the access-legality rule.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10,
        S_DONE = 2'b11
    } lsu_state_e;

    // Natural alignment for the access size; unsigned sizes exist only for loads.
    function automatic logic lsu_legal(input logic i_store, input logic [2:0] i_f3,
                                       input logic [1:0] i_off);
        logic ok;
        ok = 1'b0;
        case (i_f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~i_off[0];
            F3_W:    ok = (i_off == 2'b00);
            F3_BU:   ok = ~i_store;
            F3_HU:   ok = ~i_store & ~i_off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication and strobes, and
// load-word extraction with sign/zero extension.
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
        case (i_st_size)
            2'b00: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_offset;
            end
            2'b01: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = 4'b0011 << i_st_offset;
            end
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    assign w_shifted = i_ld_rdata >> {i_ld_offset, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_ld_data = {24'b0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'b0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage data-memory client: turns EX/MEM load/store control into a
// valid/ready bus request, stalls until done, and returns extended load data.
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  mem_exc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [31:0]           req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  resp_valid,
    input  logic [31:0]           resp_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_state_nxt;
    logic                  r_req_we;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [31:0]           r_req_wdata;
    logic [3:0]            r_req_wstrb;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic [31:0]           r_load_data;

    logic                  w_active;
    logic                  w_legal;
    logic                  w_idle;
    logic                  w_start;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [31:0]           w_ld_data;

    assign w_active = mem_read | mem_write;
    assign w_legal  = lsu_legal(mem_write, funct3, addr[1:0]);
    assign w_idle   = (r_state == S_IDLE);
    // Gating with rst_n keeps stall/mem_exc quiet while reset is held.
    assign w_start  = rst_n & w_idle & w_active & w_legal;
    assign mem_exc  = rst_n & w_idle & w_active & ~w_legal;
    assign stall    = w_start | (r_state == S_REQ) | (r_state == S_RESP);

    lsu_align u_align (
        .i_st_size   (funct3[1:0]),
        .i_st_offset (addr[1:0]),
        .i_st_data   (store_data),
        .o_st_wdata  (w_wdata),
        .o_st_wstrb  (w_wstrb),
        .i_ld_funct3 (r_f3),
        .i_ld_offset (r_off),
        .i_ld_rdata  (resp_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_REQ;
            S_REQ:   if (req_ready) w_state_nxt = r_req_we ? S_DONE : S_RESP;
            S_RESP:  if (resp_valid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_f3        <= '0;
            r_off       <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_req_we    <= mem_write;
                r_req_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                r_req_wdata <= w_wdata;
                r_req_wstrb <= mem_write ? w_wstrb : 4'b0000;
                r_f3        <= funct3;
                r_off       <= addr[1:0];
            end
            if ((r_state == S_RESP) && resp_valid) begin
                r_load_data <= w_ld_data;
            end
        end
    end

    assign req_valid = (r_state == S_REQ);
    assign req_we    = r_req_we;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_wstrb = r_req_wstrb;
    assign load_data = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random ops against a
// size/offset reference model, and reset-related sequences.
module tb_load_store_unit;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          rdy;
        int          rsp;
        logic        exc;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, mem_exc, req_valid, req_ready, req_we, resp_valid;
    logic [31:0] load_data, req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_ld = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .mem_exc(mem_exc), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rdata, input int rdy, input int rsp,
                               input logic exc, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input logic [31:0] ld);
        op_t t;
        t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.sd = sd; t.rdata = rdata;
        t.rdy = rdy; t.rsp = rsp; t.exc = exc; t.wstrb = wstrb; t.wdata = wdata; t.ld = ld;
        return t;
    endfunction

    // Reference model: derive expectations from access size, offset and signedness.
    function automatic op_t model(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rdata,
                                  input int rdy, input int rsp);
        op_t t;
        int size, off;
        logic [31:0] mask, v;
        t = mk(rd, !rd, f3, a, sd, rdata, rdy, rsp, 1'b0, 4'h0, 32'h0, 32'h0);
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || (!rd && f3[2])) t.exc = 1'b1;
        else t.exc = (off % size) != 0;
        if (!rd)
            for (int i = 0; i < 4; i++) t.wstrb[i] = (i >= off) && (i < off + size);
        t.wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                  (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
        mask = (size >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
        v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size > 0 && size < 4 && v[8*size-1]) v = v | ~mask;
        t.ld = v;
        return t;
    endfunction

    task automatic run_op(input op_t t);
        mem_read = t.rd; mem_write = t.wr; funct3 = t.f3; addr = t.addr; store_data = t.sd;
        req_ready = 1'b1; resp_valid = 1'b0;
        @(negedge clk);
        chk("mem_exc", mem_exc, t.exc);
        chk("req_valid_idle", req_valid, 0);
        if (t.exc) begin
            chk("stall_exc", stall, 0);
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            chk("req_valid_after_exc", req_valid, 0);
            chk("load_data_exc", load_data, last_ld);
            @(posedge clk); #1;
        end else begin
            chk("stall_idle", stall, 1);
            @(posedge clk); #1;
            for (int k = 0; k <= t.rdy; k++) begin
                req_ready  = (k == t.rdy);
                resp_valid = 1'($urandom % 2);
                resp_rdata = $urandom;
                @(negedge clk);
                chk("req_valid", req_valid, 1);
                chk("stall_req", stall, 1);
                chk("req_we", req_we, t.wr);
                chk("req_addr", req_addr, t.addr & 32'hFFFF_FFFC);
                chk("req_wstrb", req_wstrb, t.wstrb);
                if (t.wr) chk("req_wdata", req_wdata, t.wdata);
                @(posedge clk); #1;
            end
            if (t.rd) begin
                for (int j = 0; j <= t.rsp; j++) begin
                    req_ready  = 1'($urandom % 2);
                    resp_valid = (j == t.rsp);
                    resp_rdata = (j == t.rsp) ? t.rdata : $urandom;
                    @(negedge clk);
                    chk("stall_resp", stall, 1);
                    chk("req_valid_resp", req_valid, 0);
                    @(posedge clk); #1;
                end
                last_ld = t.ld;
            end
            req_ready = 1'b0; resp_valid = 1'($urandom % 2); resp_rdata = $urandom;
            @(negedge clk);
            chk("stall_done", stall, 0);
            chk("req_valid_done", req_valid, 0);
            chk("load_data", load_data, last_ld);
            @(posedge clk); #1;
            resp_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        op_t tbl[14];
        tbl[0]  = mk(0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0);
        tbl[1]  = mk(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 3, 0, 0, 4'b1000, 32'hA5A5_A5A5, 0);
        tbl[2]  = mk(1, 0, 3'b000, 32'h0000_3002, 0, 32'h1280_3456, 0, 0, 0, 4'b0000, 0, 32'hFFFF_FF80);
        tbl[3]  = mk(1, 0, 3'b100, 32'h0000_3002, 0, 32'h1280_3456, 0, 0, 0, 4'b0000, 0, 32'h0000_0080);
        tbl[4]  = mk(1, 0, 3'b001, 32'h0000_2001, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
        tbl[5]  = mk(1, 0, 3'b101, 32'h0000_0002, 0, 32'hBEEF_0000, 0, 0, 0, 4'b0000, 0, 32'h0000_BEEF);
        tbl[6]  = mk(0, 1, 3'b010, 32'h0000_0010, 32'h1234_5678, 0, 0, 0, 0, 4'b1111, 32'h1234_5678, 0);
        tbl[7]  = mk(0, 1, 3'b001, 32'h0000_1002, 32'h0000_CAFE, 0, 1, 0, 0, 4'b1100, 32'hCAFE_CAFE, 0);
        tbl[8]  = mk(1, 0, 3'b010, 32'h0000_0100, 0, 32'h89AB_CDEF, 2, 2, 0, 4'b0000, 0, 32'h89AB_CDEF);
        tbl[9]  = mk(1, 0, 3'b001, 32'h0000_0006, 0, 32'h8001_7FFF, 0, 1, 0, 4'b0000, 0, 32'hFFFF_8001);
        tbl[10] = mk(0, 1, 3'b100, 32'h0000_0000, 32'h55, 0, 0, 0, 1, 4'b0000, 0, 0);
        tbl[11] = mk(0, 1, 3'b010, 32'h0000_1002, 32'h1, 0, 0, 0, 1, 4'b0000, 0, 0);
        tbl[12] = mk(1, 0, 3'b011, 32'h0000_0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
        tbl[13] = mk(1, 0, 3'b000, 32'h0000_0001, 0, 32'h0000_7F00, 1, 0, 0, 4'b0000, 0, 32'h0000_007F);

        // Reset state, with a legal and an illegal request presented.
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h1;
        store_data = 0; req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_mem_exc", mem_exc, 0);
        chk("rst_stall_illegal", stall, 0);
        addr = 32'h0;
        @(negedge clk);
        chk("rst_stall_legal", stall, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_we", req_we, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_req_wstrb", req_wstrb, 0);
        chk("rst_load_data", load_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk("stale_resp_stall", stall, 0);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        chk("stale_resp_load_data", load_data, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_op(tbl[i]);

        // Reset while waiting for a load response.
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_wait_stall", stall, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", req_valid, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_load_data", load_data, 0);
        last_ld = 32'h0;
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("postrst_req_valid", req_valid, 0);
        chk("postrst_stall", stall, 0);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        chk("postrst_load_data", load_data, 0);
        @(posedge clk); #1;
        run_op(mk(1, 0, 3'b010, 32'h44, 0, 32'h0BAD_F00D, 0, 0, 0, 4'b0000, 0, 32'h0BAD_F00D));

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] f3;
            logic       rd;
            case ($urandom_range(0, 7))
                0: f3 = 3'd0;  1: f3 = 3'd1;  2: f3 = 3'd2;  3: f3 = 3'd4;
                4: f3 = 3'd5;  5: f3 = 3'd2;  6: f3 = 3'd0;  default: f3 = 3'd3;
            endcase
            rd = 1'($urandom % 2);
            run_op(model(rd, f3, $urandom, $urandom, $urandom,
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 2))));
        end

        mem_read = 1'b0; mem_write = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
